// File: rtl/systolic_ctrl_2x2_pkg.sv
// Shared types and constants for the 2x2 systolic array sequencer.
package systolic_ctrl_2x2_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned STEP_W     = 2;
  localparam int unsigned FEED_STEPS = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Operand select codes: element 0, element 1, or a forced zero operand
  localparam logic [SEL_W-1:0] SEL_E0   = 2'd0;
  localparam logic [SEL_W-1:0] SEL_E1   = 2'd1;
  localparam logic [SEL_W-1:0] SEL_ZERO = 2'd2;

  typedef struct packed {
    logic [SEL_W-1:0] a0;
    logic [SEL_W-1:0] a1;
    logic [SEL_W-1:0] b0;
    logic [SEL_W-1:0] b1;
  } sel_bus_t;

  localparam sel_bus_t SEL_IDLE = '{a0: SEL_ZERO, a1: SEL_ZERO, b0: SEL_ZERO, b1: SEL_ZERO};

  // States during which operands must be held stable by the memory side
  function automatic logic is_busy_state(input state_t s);
    return (s == ST_CLEAR) || (s == ST_FEED) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/systolic_ctrl_2x2_if.sv
// Command / array-control bundle between host, sequencer and array.
interface systolic_ctrl_2x2_if import systolic_ctrl_2x2_pkg::*; ();

  logic             start;
  logic             accumulate;
  logic             transpose_cfg;
  logic             relu_cfg;
  logic             clear;
  logic             data_valid;
  logic [SEL_W-1:0] a0_sel;
  logic [SEL_W-1:0] a1_sel;
  logic [SEL_W-1:0] b0_sel;
  logic [SEL_W-1:0] b1_sel;
  logic             transpose;
  logic             activation;
  logic             busy;
  logic             done;
  logic             result_valid;

  // Host side: issues commands, observes array controls and status
  modport master (
    output start, accumulate, transpose_cfg, relu_cfg,
    input  clear, data_valid, a0_sel, a1_sel, b0_sel, b1_sel,
    input  transpose, activation, busy, done, result_valid
  );

  // Sequencer side
  modport slave (
    input  start, accumulate, transpose_cfg, relu_cfg,
    output clear, data_valid, a0_sel, a1_sel, b0_sel, b1_sel,
    output transpose, activation, busy, done, result_valid
  );

endinterface

// File: rtl/systolic_feed_rom.sv
// Feed-step to operand-select lookup; row 1 / column 1 lag by one step.
module systolic_feed_rom import systolic_ctrl_2x2_pkg::*; (
  input  logic [STEP_W-1:0] i_step,
  output sel_bus_t          o_sel_c
);

  // Skewed 2x2 schedule: lane 0 leads, lane 1 follows one step later
  always_comb begin
    o_sel_c = SEL_IDLE;
    case (i_step)
      2'd0: begin
        o_sel_c.a0 = SEL_E0;
        o_sel_c.b0 = SEL_E0;
      end
      2'd1: begin
        o_sel_c.a0 = SEL_E1;
        o_sel_c.b0 = SEL_E1;
        o_sel_c.a1 = SEL_E0;
        o_sel_c.b1 = SEL_E0;
      end
      2'd2: begin
        o_sel_c.a1 = SEL_E1;
        o_sel_c.b1 = SEL_E1;
      end
      default: o_sel_c = SEL_IDLE;
    endcase
  end

endmodule

// File: rtl/systolic_ctrl_2x2.sv
// Sequencer for the 2x2 systolic array: clear, skewed feed, drain, done.
module systolic_ctrl_2x2 import systolic_ctrl_2x2_pkg::*; #(
  parameter int unsigned DRAIN_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  systolic_ctrl_2x2_if.slave bus
);

  localparam int unsigned         DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(FEED_STEPS - 1);

  state_t               r_state;
  logic [STEP_W-1:0]    r_step;
  logic [DRAIN_W-1:0]   r_drain;
  logic                 r_transpose;
  logic                 r_activation;
  logic                 r_clear;
  logic                 r_data_valid;
  sel_bus_t             r_sel;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_result_valid;

  state_t               w_state_nxt;
  logic [STEP_W-1:0]    w_step_nxt;
  logic [DRAIN_W-1:0]   w_drain_nxt;
  logic                 w_transpose_nxt;
  logic                 w_activation_nxt;
  logic                 w_result_valid_nxt;
  sel_bus_t             w_feed_sel;
  sel_bus_t             w_sel_nxt;

  systolic_feed_rom u_feed_rom (
    .i_step  (w_step_nxt),
    .o_sel_c (w_feed_sel)
  );

  // State and counter register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // Next state, counters, latched config and result_valid level
  always_comb begin
    w_state_nxt        = r_state;
    w_step_nxt         = r_step;
    w_drain_nxt        = r_drain;
    w_transpose_nxt    = r_transpose;
    w_activation_nxt   = r_activation;
    w_result_valid_nxt = r_result_valid;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_transpose_nxt    = bus.transpose_cfg;
          w_activation_nxt   = bus.relu_cfg;
          w_result_valid_nxt = 1'b0;
          w_step_nxt         = '0;
          w_drain_nxt        = '0;
          w_state_nxt        = bus.accumulate ? ST_FEED : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_step_nxt  = '0;
        w_state_nxt = ST_FEED;
      end
      ST_FEED: begin
        if (r_step == STEP_LAST) begin
          w_step_nxt  = '0;
          w_drain_nxt = '0;
          w_state_nxt = ST_DRAIN;
        end else begin
          w_step_nxt = r_step + STEP_W'(1);
        end
      end
      ST_DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          w_drain_nxt        = '0;
          w_result_valid_nxt = 1'b1;
          w_state_nxt        = ST_DONE;
        end else begin
          w_drain_nxt = r_drain + DRAIN_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand selects for the upcoming cycle; zero operands outside FEED
  always_comb begin
    w_sel_nxt = SEL_IDLE;
    if (w_state_nxt == ST_FEED) begin
      w_sel_nxt = w_feed_sel;
    end
  end

  // Array controls registered from the next state so they align with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clear        <= 1'b0;
      r_data_valid   <= 1'b0;
      r_sel          <= SEL_IDLE;
      r_transpose    <= 1'b0;
      r_activation   <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_clear        <= (w_state_nxt == ST_CLEAR);
      r_data_valid   <= (w_state_nxt == ST_FEED);
      r_sel          <= w_sel_nxt;
      r_transpose    <= w_transpose_nxt;
      r_activation   <= w_activation_nxt;
      r_busy         <= is_busy_state(w_state_nxt);
      r_done         <= (w_state_nxt == ST_DONE);
      r_result_valid <= w_result_valid_nxt;
    end
  end

  assign bus.clear        = r_clear;
  assign bus.data_valid   = r_data_valid;
  assign bus.a0_sel       = r_sel.a0;
  assign bus.a1_sel       = r_sel.a1;
  assign bus.b0_sel       = r_sel.b0;
  assign bus.b1_sel       = r_sel.b1;
  assign bus.transpose    = r_transpose;
  assign bus.activation   = r_activation;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.result_valid = r_result_valid;

endmodule

// File: tb/tb_systolic_ctrl_2x2.sv
// Directed bench for systolic_ctrl_2x2 with a behavioural 2x2 array model.
module tb_systolic_ctrl_2x2;

  logic clk = 1'b0;
  logic rst;

  systolic_ctrl_2x2_if bus ();

  systolic_ctrl_2x2 #(.DRAIN_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Operand memories and the output-stationary array model
  int A [2][2];
  int B [2][2];
  int c [2][2] = '{'{0, 0}, '{0, 0}};
  int a0_q = 0, a1_q = 0, b0_q = 0, b1_q = 0;

  function automatic int opnd_a(input logic row, input logic [1:0] sel);
    if (!bus.data_valid || sel[1]) return 0;
    return A[row][sel[0]];
  endfunction

  function automatic int opnd_b(input logic col, input logic [1:0] sel);
    if (!bus.data_valid || sel[1]) return 0;
    return bus.transpose ? B[col][sel[0]] : B[sel[0]][col];
  endfunction

  function automatic int c_rd(input logic r, input logic k);
    int v;
    v = c[r][k];
    return (bus.activation && v < 0) ? 0 : v;
  endfunction

  // A streams right, B streams down, one register per hop
  always @(posedge clk) begin
    if (bus.clear) begin
      c[0][0] <= 0; c[0][1] <= 0; c[1][0] <= 0; c[1][1] <= 0;
      a0_q <= 0; a1_q <= 0; b0_q <= 0; b1_q <= 0;
    end else begin
      c[0][0] <= c[0][0] + opnd_a(1'b0, bus.a0_sel) * opnd_b(1'b0, bus.b0_sel);
      c[0][1] <= c[0][1] + a0_q * opnd_b(1'b1, bus.b1_sel);
      c[1][0] <= c[1][0] + opnd_a(1'b1, bus.a1_sel) * b0_q;
      c[1][1] <= c[1][1] + a1_q * b1_q;
      a0_q <= opnd_a(1'b0, bus.a0_sel);
      a1_q <= opnd_a(1'b1, bus.a1_sel);
      b0_q <= opnd_b(1'b0, bus.b0_sel);
      b1_q <= opnd_b(1'b1, bus.b1_sel);
    end
  end

  // Per-run observations
  int               done_cyc;
  int               clear_n;
  int               clear_cyc;
  int               feed_n;
  logic [3:0][7:0]  feed_sel;
  logic             rv_c1;
  logic             busy_at_done;
  logic             rv_at_done;
  logic             tr_at_done;
  logic             act_at_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [7:0] sels();
    return {bus.a0_sel, bus.a1_sel, bus.b0_sel, bus.b1_sel};
  endfunction

  // One command from IDLE; cycle 1 is the cycle after the accepting edge
  task automatic run_op(input logic acc, input logic tr, input logic relu, input int pulse_cyc);
    @(posedge clk); #1;
    bus.start         = 1'b1;
    bus.accumulate    = acc;
    bus.transpose_cfg = tr;
    bus.relu_cfg      = relu;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_cyc  = -1;
    clear_n   = 0;
    clear_cyc = -1;
    feed_n    = 0;
    feed_sel  = '0;
    rv_c1     = bus.result_valid;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (bus.clear) begin
        clear_n++;
        clear_cyc = cyc;
      end
      if (bus.data_valid) begin
        if (feed_n < 4) feed_sel[feed_n[1:0]] = sels();
        feed_n++;
      end
      if (bus.done) begin
        done_cyc     = cyc;
        busy_at_done = bus.busy;
        rv_at_done   = bus.result_valid;
        tr_at_done   = bus.transpose;
        act_at_done  = bus.activation;
        break;
      end
      bus.start = (cyc == pulse_cyc);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic check_c(input string tag, input int e00, input int e01, input int e10, input int e11);
    check({tag, "_c00"}, 32'(c_rd(1'b0, 1'b0)), 32'(e00));
    check({tag, "_c01"}, 32'(c_rd(1'b0, 1'b1)), 32'(e01));
    check({tag, "_c10"}, 32'(c_rd(1'b1, 1'b0)), 32'(e10));
    check({tag, "_c11"}, 32'(c_rd(1'b1, 1'b1)), 32'(e11));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_clear"}, 32'(bus.clear), 32'(0));
    check({tag, "_dv"},    32'(bus.data_valid), 32'(0));
    check({tag, "_sels"},  32'(sels()), 32'(8'hAA));
    check({tag, "_tr"},    32'(bus.transpose), 32'(0));
    check({tag, "_act"},   32'(bus.activation), 32'(0));
    check({tag, "_busy"},  32'(bus.busy), 32'(0));
    check({tag, "_done"},  32'(bus.done), 32'(0));
    check({tag, "_rv"},    32'(bus.result_valid), 32'(0));
  endtask

  task automatic load_basic();
    A = '{'{1, 2}, '{3, 4}};
    B = '{'{5, 6}, '{7, 8}};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra_done;
    int extra_busy;
    rst               = 1'b0;
    bus.start         = 1'b0;
    bus.accumulate    = 1'b0;
    bus.transpose_cfg = 1'b0;
    bus.relu_cfg      = 1'b0;
    load_basic();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // Basic multiply
    run_op(1'b0, 1'b0, 1'b0, -1);
    check("basic_latency", 32'(done_cyc), 32'(7));
    check("basic_clear_n", 32'(clear_n), 32'(1));
    check("basic_clear_cyc", 32'(clear_cyc), 32'(1));
    check("basic_feed_n", 32'(feed_n), 32'(4));
    check("basic_step0", 32'(feed_sel[0]), 32'(8'h22));
    check("basic_step1", 32'(feed_sel[1]), 32'(8'h44));
    check("basic_step2", 32'(feed_sel[2]), 32'(8'h99));
    check("basic_step3", 32'(feed_sel[3]), 32'(8'hAA));
    check("basic_busy_done", 32'(busy_at_done), 32'(0));
    check("basic_rv_done", 32'(rv_at_done), 32'(1));
    check_c("basic", 19, 22, 43, 50);

    // Start in the DONE cycle must be ignored
    bus.start      = 1'b1;
    bus.accumulate = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    extra_busy = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy || bus.clear || bus.data_valid) extra_busy++;
      @(posedge clk); #1;
    end
    check("done_start_ignored", 32'(extra_busy), 32'(0));
    check("done_start_rv_held", 32'(bus.result_valid), 32'(1));

    // Accumulate onto previous sums
    run_op(1'b1, 1'b0, 1'b0, -1);
    check("acc_rv_drop", 32'(rv_c1), 32'(0));
    check("acc_latency", 32'(done_cyc), 32'(6));
    check("acc_clear_n", 32'(clear_n), 32'(0));
    check_c("acc", 38, 44, 86, 100);

    // Transpose, flag held while results are read
    run_op(1'b0, 1'b1, 1'b0, -1);
    check("tr_latency", 32'(done_cyc), 32'(7));
    check("tr_flag_done", 32'(tr_at_done), 32'(1));
    check_c("tr", 17, 23, 39, 53);
    repeat (3) @(posedge clk);
    #1;
    check("tr_flag_hold", 32'(bus.transpose), 32'(1));
    check("tr_rv_hold", 32'(bus.result_valid), 32'(1));

    // ReLU on and off
    A = '{'{-1, 0}, '{0, -1}};
    B = '{'{1, 0}, '{0, 1}};
    run_op(1'b0, 1'b0, 1'b1, -1);
    check("relu_act", 32'(act_at_done), 32'(1));
    check("relu_tr_cleared", 32'(tr_at_done), 32'(0));
    check_c("relu_on", 0, 0, 0, 0);
    run_op(1'b0, 1'b0, 1'b0, -1);
    check("norelu_act", 32'(act_at_done), 32'(0));
    check_c("relu_off", -1, 0, 0, -1);

    // Start during FEED step 1 ignored, no extra done
    load_basic();
    run_op(1'b0, 1'b0, 1'b0, 3);
    check("busy_start_latency", 32'(done_cyc), 32'(7));
    check_c("busy_start", 19, 22, 43, 50);
    extra_done = 0;
    extra_busy = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done) extra_done++;
      if (bus.busy) extra_busy++;
    end
    check("busy_start_extra_done", 32'(extra_done), 32'(0));
    check("busy_start_extra_busy", 32'(extra_busy), 32'(0));

    // Reset abort at FEED step 2
    @(posedge clk); #1;
    bus.start         = 1'b1;
    bus.accumulate    = 1'b0;
    bus.transpose_cfg = 1'b1;
    bus.relu_cfg      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_dv", 32'(bus.data_valid), 32'(1));
    check("abort_pre_sels", 32'(sels()), 32'(8'h99));
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst = 1'b1;
    run_op(1'b0, 1'b0, 1'b0, -1);
    check("post_abort_latency", 32'(done_cyc), 32'(7));
    check_c("post_abort", 19, 22, 43, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl_2x2.md
Name: systolic_ctrl_2x2

Overview:
Sequencer for the 2x2 weight-stationary-free systolic array. It accepts a start command, optionally clears the PE accumulators, and drives data_valid and the four operand-select buses with the skewed 2x2 feed schedule. It then waits for the array to drain and signals done with a registered result_valid. It sits between the top-level command/memory interface and the array. Operands come straight from memory and must be held stable while busy is high.

Parameters:
DRAIN_CYCLES, 1, extra cycles after the last feed step before results are declared valid (1..7)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
start  input  1  command pulse; sampled only in IDLE
accumulate  input  1  sampled with start; 1 = skip CLEAR and add onto existing sums
transpose_cfg  input  1  sampled with start; selects B vs B^T
relu_cfg  input  1  sampled with start; ReLU enable
clear  output  1  PE accumulator clear
data_valid  output  1  operand gate to array
a0_sel  output  2  row-0 operand select
a1_sel  output  2  row-1 operand select
b0_sel  output  2  col-0 operand select
b1_sel  output  2  col-1 operand select
transpose  output  1  latched transpose_cfg
activation  output  1  latched relu_cfg
busy  output  1  high from CLEAR/first FEED through DRAIN; operands must be held stable
done  output  1  one-cycle pulse in DONE
result_valid  output  1  level; c outputs are final

Behaviour:
- Reset (rst low, async): state IDLE, step=0, drain count=0. clear=0, data_valid=0, all sel=2, transpose=0, activation=0, busy=0, done=0, result_valid=0. Reset mid-operation aborts immediately. The array contents are not defined afterward.
- States: IDLE, CLEAR, FEED, DRAIN, DONE. Outputs are decoded from registered state and counters.
- IDLE + start=1 at edge E0:
  - Latch accumulate, transpose_cfg and relu_cfg.
  - Next state is CLEAR if accumulate=0, otherwise FEED.
  - result_valid drops at E0.
- CLEAR: one cycle. clear=1, data_valid=0, busy=1. Next state FEED.
- FEED: 4 cycles, step 0..3. data_valid=1, busy=1.
  - a0_sel and b0_sel by step: 0, 1, 2, 2.
  - a1_sel and b1_sel by step: 2, 0, 1, 2.
  - Code 2 means zero operand. This implements the one-cycle skew for row 1 and column 1.
- DRAIN: DRAIN_CYCLES cycles. data_valid=0, sels=2, busy=1. Next state DONE.
- DONE: one cycle. done=1 and busy=0. result_valid is set at entry and held until the next accepted start. Next state IDLE.
- Latency with accumulate=0 and DRAIN_CYCLES=1:
  - CLEAR in cycle 1 after E0.
  - FEED in cycles 2-5.
  - DRAIN in cycle 6.
  - done in cycle 7.
  - With accumulate=1, everything is one cycle earlier.
- Timing rule: done latency = (accumulate ? 0 : 1) + 4 + DRAIN_CYCLES + 1.
- start outside IDLE is ignored, with no queuing. start in the DONE cycle is also ignored.
- transpose and activation hold their latched values from start through the next accepted start. activation therefore stays valid while results are read.
- Step counter is 2 bits and never wraps within FEED. Drain counter width is clog2(DRAIN_CYCLES+1).

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, CLEAR=1, FEED=2, DRAIN=3, DONE=4, 3 bits);
  - select codes SEL_E0=2'd0, SEL_E1=2'd1, SEL_ZERO=2'd2;
  - FEED_STEPS=4.
- One sub-module is natural: systolic_feed_rom, a combinational step-to-4-selects lookup.
- The FSM and counters stay in systolic_ctrl_2x2.

Test Plan:
- Basic multiply. Controller drives the array with A=[[1,2],[3,4]] (weight0..3) and B=[[5,6],[7,8]] (input0..3), accumulate=0. Expected:
  - done in cycle 7 after E0;
  - C=[[19,22],[43,50]];
  - sel sequence per step exactly as specified.
- Transpose. Same operands with transpose_cfg=1 -> C=[[17,23],[39,53]], with transpose=1 held through result_valid.
- Accumulate. Rerun the basic case with accumulate=1 -> no clear pulse, done in cycle 6, C=[[38,44],[86,100]].
- ReLU. A=[[-1,0],[0,-1]], B=identity, relu_cfg=1 -> c00=c11=0 and c01=c10=0. With relu_cfg=0 -> c00=c11=-1.
- Busy command handling. Pulse start during FEED step 1 -> ignored: no extra done, done count=1. A start in the cycle after done is accepted.
- Reset abort. Assert rst low at FEED step 2 -> all outputs at reset values in the same cycle (async). After release, a new start completes normally with correct C.
